// File: rtl/axi_ram_slave.sv
// rtl/axi_ram_slave.sv - AXI3 slave backed by a word-addressed on-chip RAM
module axi_ram_slave #(
    parameter int MEM_AW   = 14,
    parameter int RD_DELAY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam int DEPTH = 1 << MEM_AW;
    localparam logic [3:0] WAIT_LAST = 4'(RD_DELAY - 1);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [31:0] mem [DEPTH];

    // Holds the address-channel readies low for the first cycle after reset.
    logic live;

    r_state_t    r_state, r_next;
    logic [3:0]  r_id;
    logic [31:0] r_addr, r_step, r_addr_nxt, r_rd_addr, r_word, r_data;
    logic [7:0]  r_len, r_beat;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic        r_bad, r_rd_bad, ar_bad, ar_hs, r_hs;
    logic [3:0]  r_wait;

    w_state_t    w_state, w_next;
    logic [3:0]  w_id;
    logic [31:0] w_addr, w_step;
    logic [7:0]  w_len, w_beat;
    logic [2:0]  w_size;
    logic [1:0]  w_burst;
    logic        w_bad, w_err, aw_bad, aw_hs, w_hs, w_final;

    logic unused_ok;
    assign unused_ok = ^wid;

    always_ff @(posedge clk) begin
        if (rst) live <= 1'b0;
        else     live <= 1'b1;
    end

    assign arready = live && (r_state == R_IDLE);
    assign rvalid  = (r_state == R_BURST);
    assign rlast   = rvalid && (r_beat == r_len);
    assign rid     = r_id;
    assign rdata   = r_data;
    assign rresp   = (rvalid && r_bad) ? 2'b10 : 2'b00;
    assign ar_hs   = arvalid && arready;
    assign r_hs    = rvalid && rready;
    assign ar_bad  = arburst[1] || (arsize > 3'd2);

    assign r_step     = (r_burst == 2'b01) ? (32'd1 << r_size) : 32'd0;
    assign r_addr_nxt = r_addr + r_step;

    // One RAM read port: the AR address on accept, the held address while
    // waiting, and the following beat's address as a prefetch during the burst.
    always_comb begin
        r_rd_addr = r_addr;
        r_rd_bad  = r_bad;
        if (r_state == R_IDLE) begin
            r_rd_addr = araddr;
            r_rd_bad  = ar_bad;
        end else if (r_state == R_BURST) begin
            r_rd_addr = r_addr_nxt;
        end
    end
    assign r_word = r_rd_bad ? 32'd0 : mem[r_rd_addr[MEM_AW+1:2]];

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = (RD_DELAY == 0) ? R_BURST : R_WAIT;
            R_WAIT:  if (r_wait == WAIT_LAST) r_next = R_BURST;
            R_BURST: if (r_hs && rlast) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_bad   <= 1'b0;
            r_beat  <= '0;
            r_wait  <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (ar_hs) begin
                    r_id    <= arid;
                    r_addr  <= araddr;
                    r_len   <= arlen;
                    r_size  <= arsize;
                    r_burst <= arburst;
                    r_bad   <= ar_bad;
                    r_beat  <= '0;
                    r_wait  <= '0;
                    r_data  <= r_word;
                end
                R_WAIT: begin
                    r_wait <= r_wait + 4'd1;
                    r_data <= r_word;
                end
                R_BURST: if (r_hs) begin
                    r_addr <= r_addr_nxt;
                    r_beat <= r_beat + 8'd1;
                    r_data <= r_word;
                end
                default: ;
            endcase
        end
    end

    assign awready = live && (w_state == W_IDLE);
    assign wready  = (w_state == W_DATA);
    assign bvalid  = (w_state == W_RESP);
    assign bid     = w_id;
    assign bresp   = (bvalid && (w_bad || w_err)) ? 2'b10 : 2'b00;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign w_final = (w_beat == w_len);
    assign aw_bad  = awburst[1] || (awsize > 3'd2);
    assign w_step  = (w_burst == 2'b01) ? (32'd1 << w_size) : 32'd0;

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && w_final) w_next = W_RESP;
            W_RESP:  if (bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_bad   <= 1'b0;
            w_err   <= 1'b0;
            w_beat  <= '0;
        end else if (aw_hs) begin
            w_id    <= awid;
            w_addr  <= awaddr;
            w_len   <= awlen;
            w_size  <= awsize;
            w_burst <= awburst;
            w_bad   <= aw_bad;
            w_err   <= 1'b0;
            w_beat  <= '0;
        end else if (w_hs) begin
            w_addr <= w_addr + w_step;
            w_beat <= w_beat + 8'd1;
            if (wlast != w_final) w_err <= 1'b1;
        end
    end

    // RAM is deliberately outside reset so data survives a mid-burst reset.
    always_ff @(posedge clk) begin
        if (w_hs && !w_bad) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[w_addr[MEM_AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axi_ram_slave.sv
// tb/tb_axi_ram_slave.sv - directed and random checks of axi_ram_slave against a word-array model
module tb_axi_ram_slave;
    localparam int MEM_AW   = 14;
    localparam int RD_DELAY = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  arid = '0, awid = '0, wid = '0;
    logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
    logic [7:0]  arlen = '0, awlen = '0;
    logic [2:0]  arsize = '0, awsize = '0;
    logic [1:0]  arburst = '0, awburst = '0;
    logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
    logic        rready = 1'b0, bready = 1'b0;
    logic [3:0]  wstrb = '0;
    logic        arready, rvalid, rlast, awready, wready, bvalid;
    logic [3:0]  rid, bid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model [int];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];

    axi_ram_slave #(.MEM_AW(MEM_AW), .RD_DELAY(RD_DELAY)) dut (
        .clk(clk), .rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[MEM_AW+1:2]);
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] base, input int i,
                                              input logic [2:0] size, input logic [1:0] burst);
        return (burst == 2'b01) ? base + 32'(i) * (32'd1 << size) : base;
    endfunction

    function automatic bit unsup(input logic [2:0] size, input logic [1:0] burst);
        return burst[1] || (size > 3'd2);
    endfunction

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int last_beat);
        logic [31:0] cur;
        logic [1:0]  exp_resp;
        int          idx;
        exp_resp = (unsup(size, burst) || last_beat != int'(len)) ? 2'b10 : 2'b00;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        for (int k = 0; k < 20 && !awready; k++) step();
        check("awready", awready, 1);
        step();
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == last_beat); wid = id;
            check("wready", wready, 1);
            step();
            if (!unsup(size, burst)) begin
                idx = widx(beat_addr(addr, i, size, burst));
                cur = model.exists(idx) ? model[idx] : 32'h0;
                for (int l = 0; l < 4; l++) if (ws[i][l]) cur[8*l +: 8] = wd[i][8*l +: 8];
                model[idx] = cur;
            end
        end
        wvalid = 1'b0; wlast = 1'b0;
        check("bvalid_rise", bvalid, 1);
        step();
        check("bvalid_hold", bvalid, 1);
        check("bid", bid, id);
        check("bresp", bresp, exp_resp);
        bready = 1'b1;
        step();
        bready = 1'b0;
        check("bvalid_drop", bvalid, 0);
        check("awready_after_b", awready, 1);
    endtask

    // mode 0: rready held high, 1: toggling, 2: random
    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode);
        int          lat, beat, cyc;
        bit          stalled;
        logic [31:0] p_data, exp;
        logic [3:0]  p_id;
        logic        p_last;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        rready = 1'b0;
        for (int k = 0; k < 20 && !arready; k++) step();
        check("arready", arready, 1);
        step();
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 40) begin step(); lat++; end
        check("r_latency", lat, RD_DELAY);
        beat = 0; cyc = 0; stalled = 1'b0;
        p_data = '0; p_id = '0; p_last = 1'b0;
        while (beat <= int'(len) && cyc < 3000) begin
            case (mode)
                0:       rready = 1'b1;
                1:       rready = (cyc % 2) == 1;
                default: rready = 1'($urandom_range(0, 1));
            endcase
            if (mode == 0) check("r_b2b", rvalid, 1);
            if (rvalid) begin
                if (stalled) begin
                    check("r_stall_data", rdata, p_data);
                    check("r_stall_id", rid, p_id);
                    check("r_stall_last", rlast, p_last);
                end
                if (rready) begin
                    exp = unsup(size, burst) ? 32'h0 : model[widx(beat_addr(addr, beat, size, burst))];
                    check("rdata", rdata, exp);
                    check("rid", rid, id);
                    check("rresp", rresp, unsup(size, burst) ? 2'b10 : 2'b00);
                    check("rlast", rlast, beat == int'(len));
                    beat++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    p_data = rdata; p_id = rid; p_last = rlast;
                end
            end
            step();
            cyc++;
        end
        rready = 1'b0;
        check("read_beats", beat, int'(len) + 1);
        check("rvalid_end", rvalid, 0);
        check("arready_after_r", arready, 1);
    endtask

    initial begin
        int          beat;
        logic [31:0] base;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;

        // reset values
        step(); step();
        check("rst_arready", arready, 0);
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_ids", {rid, bid}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_resps", {rresp, bresp}, 0);
        rst = 1'b0;
        check("post_rst_arready", arready, 0);
        check("post_rst_awready", awready, 0);
        step();
        check("live_arready", arready, 1);
        check("live_awready", awready, 1);

        // single write then read
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        do_write(4'd5, 32'h100, 8'd0, 3'd2, 2'b01, 0);
        do_read(4'd3, 32'h100, 8'd0, 3'd2, 2'b01, 0);

        // INCR burst of 8
        for (int i = 0; i < 8; i++) begin wd[i] = 32'(i); ws[i] = 4'hF; end
        do_write(4'd1, 32'h2000, 8'd7, 3'd2, 2'b01, 7);
        do_read(4'd2, 32'h2000, 8'd7, 3'd2, 2'b01, 0);

        // byte strobes
        wd[0] = 32'h11223344; ws[0] = 4'hF;
        do_write(4'd0, 32'h40, 8'd0, 3'd2, 2'b01, 0);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
        do_write(4'd0, 32'h40, 8'd0, 3'd2, 2'b01, 0);
        do_read(4'd7, 32'h40, 8'd0, 3'd2, 2'b01, 0);
        check("strobe_model", model[widx(32'h40)], 32'h11BB33DD);

        // back-pressure
        do_read(4'd9, 32'h2000, 8'd3, 3'd2, 2'b01, 1);

        // unsupported read burst and wlast mismatch
        do_read(4'd4, 32'h2000, 8'd3, 3'd2, 2'b10, 0);
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hC0DE_0000 + 32'(i); ws[i] = 4'hF; end
        do_write(4'd6, 32'h3000, 8'd3, 3'd2, 2'b01, 1);
        do_read(4'd6, 32'h3000, 8'd3, 3'd2, 2'b01, 2);

        // unsupported write discarded
        wd[0] = 32'h0BADF00D; ws[0] = 4'hF;
        do_write(4'd8, 32'h100, 8'd0, 3'd3, 2'b01, 0);
        do_read(4'd8, 32'h100, 8'd0, 3'd2, 2'b01, 0);

        // 256-beat burst crossing the top of the aliased space
        for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(4'd10, 32'h0001_FF00, 8'd255, 3'd2, 2'b01, 255);
        do_read(4'd11, 32'h0001_FF00, 8'd255, 3'd2, 2'b01, 2);

        // random bursts
        for (int t = 0; t < 6; t++) begin
            base  = $urandom;
            len   = 8'($urandom_range(0, 15));
            size  = 3'($urandom_range(0, 2));
            burst = 2'($urandom_range(0, 1));
            for (int i = 0; i <= int'(len); i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
            do_write(4'($urandom), base, len, size, burst, int'(len));
            for (int i = 0; i <= int'(len); i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
            do_write(4'($urandom), base, len, size, burst, int'(len));
            do_read(4'($urandom), base, len, size, burst, 2);
        end

        // reset during beat 2 of a 4-beat read
        arid = 4'd12; araddr = 32'h2000; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        for (int k = 0; k < 20 && !arready; k++) step();
        check("rr_arready", arready, 1);
        step();
        arvalid = 1'b0;
        rready = 1'b1;
        beat = 0;
        for (int k = 0; k < 40 && beat < 2; k++) begin
            if (rvalid) begin
                check("rr_rdata", rdata, model[widx(32'h2000 + 32'(4 * beat))]);
                beat++;
            end
            step();
        end
        check("rr_beat2_valid", rvalid, 1);
        rst = 1'b1;
        step();
        check("rr_rvalid_reset", rvalid, 0);
        check("rr_rlast_reset", rlast, 0);
        rst = 1'b0;
        rready = 1'b0;
        check("rr_arready_first", arready, 0);
        step();
        check("rr_arready_live", arready, 1);
        do_read(4'd13, 32'h2000, 8'd3, 3'd2, 2'b01, 0);
        do_read(4'd14, 32'h40, 8'd0, 3'd2, 2'b01, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
